// File: rtl/memlibc_mbist_pkg.sv
// Shared definitions for the memlibc memory BIST assembly.
//   state_e      : fail-capture session state (IDLE / ARMED / FROZEN)
//   DEF_*_W      : default datapath widths used by the BIST blocks
package memlibc_mbist_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

endpackage

// File: rtl/memlibc_mbist_fail_capture_cmp.sv
// Combinational masked compare of one read word against its expected word.
//   data     : memory read data
//   exp_word : expected data, polarity already applied
//   mask     : 1 = bit excluded from the compare
//   diff     : per-bit mismatch with masked bits forced to 0
//   any_fail : at least one unmasked bit differs
module memlibc_mbist_fail_capture_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] exp_word,
  input  logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] diff,
  output logic              any_fail
);

  assign diff     = (data ^ exp_word) & ~mask;
  assign any_fail = |diff;

endmodule

// File: rtl/memlibc_mbist_fail_capture.sv
// Result-capture stage of the memlibc BIST: two-stage pipelined masked
// compare plus session results (sticky GO/FAIL, saturating fail count,
// first-fail address and bit-difference log).
//   bist_clk, bist_rst           : clock, synchronous active-high reset
//   session_start / session_end  : open (clear results) / close a session
//   stop_on_fail                 : freeze capture after the first fail
//   rd_valid, rd_addr, rd_data   : read beat from the memory under test
//   exp_data, exp_inv, cmp_mask  : expected word, polarity select, ignore mask
//   busy, go, frozen             : session status
//   fail_pulse, fail_sticky      : per-compare strobe / session fail flag
//   fail_cnt, first_addr, first_diff : fail count and first-fail log
module memlibc_mbist_fail_capture
  import memlibc_mbist_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              bist_clk,
  input  logic              bist_rst,
  input  logic              session_start,
  input  logic              session_end,
  input  logic              stop_on_fail,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_inv,
  input  logic [DATA_W-1:0] cmp_mask,
  output logic              busy,
  output logic              go,
  output logic              fail_pulse,
  output logic              fail_sticky,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_addr,
  output logic [DATA_W-1:0] first_diff,
  output logic              frozen
);

  state_e              state, state_nxt;
  logic                v1;
  logic [ADDR_W-1:0]   addr1;
  logic [DATA_W-1:0]   d1, e1, m1;
  logic [DATA_W-1:0]   diff;
  logic                any_diff;
  logic                fail;

  memlibc_mbist_fail_capture_cmp #(.DATA_W(DATA_W)) u_cmp (
    .data     (d1),
    .exp_word (e1),
    .mask     (m1),
    .diff     (diff),
    .any_fail (any_diff)
  );

  assign fail = v1 & any_diff;

  // session_start overrides everything, including a simultaneous session_end
  always_comb begin
    state_nxt = state;
    if (session_start) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: begin
          if (session_end)               state_nxt = ST_IDLE;
          else if (fail && stop_on_fail) state_nxt = ST_FROZEN;
        end
        ST_FROZEN: if (session_end) state_nxt = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      state       <= ST_IDLE;
      v1          <= 1'b0;
      addr1       <= '0;
      d1          <= '0;
      e1          <= '0;
      m1          <= '0;
      fail_pulse  <= 1'b0;
      fail_sticky <= 1'b0;
      fail_cnt    <= '0;
      first_addr  <= '0;
      first_diff  <= '0;
    end else begin
      state <= state_nxt;
      // stage 1: only ARMED accepts reads; a start edge flushes the beat
      v1    <= rd_valid & (state == ST_ARMED) & ~session_start;
      addr1 <= rd_addr;
      d1    <= rd_data;
      e1    <= exp_data ^ {DATA_W{exp_inv}};
      m1    <= cmp_mask;
      // stage 2: a start edge drops the retiring entry along with the results
      if (session_start) begin
        fail_pulse  <= 1'b0;
        fail_sticky <= 1'b0;
        fail_cnt    <= '0;
        first_addr  <= '0;
        first_diff  <= '0;
      end else begin
        fail_pulse <= fail;
        if (fail) begin
          fail_sticky <= 1'b1;
          if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
          // log only the first fail of the session
          if (!fail_sticky) begin
            first_addr <= addr1;
            first_diff <= diff;
          end
        end
      end
    end
  end

  assign busy   = (state != ST_IDLE);
  assign frozen = (state == ST_FROZEN);
  assign go     = ~fail_sticky;

endmodule

// File: tb/tb_memlibc_mbist_fail_capture.sv
// Bench for memlibc_mbist_fail_capture: a behavioural model queues expected
// outputs per driven cycle and they are popped after each edge, plus a
// table of single-compare vectors and hand-written session sequences.
module tb_memlibc_mbist_fail_capture;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 8;

  logic          bist_clk = 1'b0;
  logic          bist_rst = 1'b1;
  logic          session_start = 1'b0, session_end = 1'b0, stop_on_fail = 1'b0;
  logic          rd_valid = 1'b0, exp_inv = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data = '0, exp_data = '0, cmp_mask = '0;
  logic          busy, go, fail_pulse, fail_sticky, frozen;
  logic [CW-1:0] fail_cnt;
  logic [AW-1:0] first_addr;
  logic [DW-1:0] first_diff;

  always #5 bist_clk = ~bist_clk;

  memlibc_mbist_fail_capture #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .bist_clk(bist_clk), .bist_rst(bist_rst),
    .session_start(session_start), .session_end(session_end),
    .stop_on_fail(stop_on_fail), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .exp_data(exp_data), .exp_inv(exp_inv),
    .cmp_mask(cmp_mask), .busy(busy), .go(go), .fail_pulse(fail_pulse),
    .fail_sticky(fail_sticky), .fail_cnt(fail_cnt), .first_addr(first_addr),
    .first_diff(first_diff), .frozen(frozen)
  );

  typedef struct {
    logic rst, start, stop, sof, rv, inv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data, exp, mask;
  } in_t;
  typedef logic [54:0] obs_t; // {busy,go,fail_pulse,fail_sticky,frozen,cnt,addr,diff}
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] diff; int due; } pend_t;
  typedef struct { logic [DW-1:0] data, exp, mask; logic inv, fail; logic [DW-1:0] diff; } row_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;
  obs_t  exp_q[$];
  pend_t pend[$];

  // model state: 0 idle, 1 armed, 2 frozen
  logic [1:0]    ms = 2'd0;
  logic          m_fp = 1'b0, m_fs = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic [AW-1:0] m_fa = '0;
  logic [DW-1:0] m_fd = '0;

  function automatic obs_t dut_obs();
    return {busy, go, fail_pulse, fail_sticky, frozen, fail_cnt, first_addr, first_diff};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  task automatic model_step(input in_t v);
    logic acc;
    pend_t r;
    logic [DW-1:0] e;
    acc = v.rv && (ms == 2'd1) && !v.start && !v.rst;
    if (v.rst || v.start) begin
      ms = v.rst ? 2'd0 : 2'd1;
      m_fp = 0; m_fs = 0; m_cnt = '0; m_fa = '0; m_fd = '0;
      pend.delete();
    end else begin
      m_fp = 0;
      if (pend.size() > 0 && pend[0].due == cyc_n) begin
        r = pend.pop_front();
        if (r.diff != '0) begin
          m_fp = 1;
          if (!m_fs) begin m_fa = r.addr; m_fd = r.diff; end
          m_fs = 1;
          if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
      end
      if (ms == 2'd1 && v.stop)              ms = 2'd0;
      else if (ms == 2'd1 && m_fp && v.sof)  ms = 2'd2;
      else if (ms == 2'd2 && v.stop)         ms = 2'd0;
    end
    if (acc) begin
      e = v.inv ? ~v.exp : v.exp;
      r.addr = v.addr;
      r.diff = (v.data ^ e) & ~v.mask;
      r.due  = cyc_n + 1;
      pend.push_back(r);
    end
    cyc_n++;
    exp_q.push_back({ms != 2'd0, !m_fs, m_fp, m_fs, ms == 2'd2, m_cnt, m_fa, m_fd});
  endtask

  task automatic cyc(input in_t v);
    obs_t e;
    @(negedge bist_clk);
    bist_rst = v.rst; session_start = v.start; session_end = v.stop;
    stop_on_fail = v.sof; rd_valid = v.rv; rd_addr = v.addr;
    rd_data = v.data; exp_data = v.exp; exp_inv = v.inv; cmp_mask = v.mask;
    model_step(v);
    @(posedge bist_clk); #1;
    e = exp_q.pop_front();
    check($sformatf("cyc%0d outputs", cyc_n), 64'(dut_obs()), 64'(e));
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic in_t rd(input int a, input logic [DW-1:0] d, input logic [DW-1:0] x,
                             input logic inv, input logic [DW-1:0] m, input logic sof);
    in_t v;
    v = idle();
    v.rv = 1; v.addr = AW'(a); v.data = d; v.exp = x; v.inv = inv; v.mask = m; v.sof = sof;
    return v;
  endfunction

  in_t s_rst, s_start, s_end, s_both;
  row_t tbl[7];

  initial begin
    tbl[0] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[3] = '{32'h000000F0, 32'h0, 32'h000000F0, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{32'h000000F0, 32'h0, 32'h00000030, 1'b0, 1'b1, 32'h000000C0};
    tbl[5] = '{32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{32'h12345678, 32'hFFFFFFFF, 32'hFFFF0000, 1'b1, 1'b1, 32'h00005678};
    s_rst = idle();   s_rst.rst = 1;
    s_start = idle(); s_start.start = 1;
    s_end = idle();   s_end.stop = 1;
    s_both = idle();  s_both.start = 1; s_both.stop = 1;

    // reset, then reads in IDLE are ignored
    cyc(s_rst); cyc(s_rst);
    check("reset go", 64'(go), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset cnt", 64'(fail_cnt), 64'd0);
    cyc(rd(1, 32'h1, 32'h0, 0, 32'h0, 0)); cyc(idle()); cyc(idle());
    check("idle read ignored", 64'(fail_sticky), 64'd0);

    // table of single compares, each in a fresh session
    for (int i = 0; i < 7; i++) begin
      cyc(s_start);
      cyc(rd(5, tbl[i].data, tbl[i].exp, tbl[i].inv, tbl[i].mask, 0));
      cyc(idle());
      check($sformatf("tbl%0d fail_pulse", i), 64'(fail_pulse), 64'(tbl[i].fail));
      check($sformatf("tbl%0d first_diff", i), 64'(first_diff), 64'(tbl[i].diff));
      check($sformatf("tbl%0d go", i), 64'(go), 64'(!tbl[i].fail));
      cyc(idle());
    end

    // two fails: log keeps the first
    cyc(s_start);
    cyc(rd(3, 32'h1, 32'h0, 0, 32'h0, 0));
    cyc(rd(7, 32'h80, 32'h0, 0, 32'h0, 0));
    cyc(idle()); cyc(idle());
    check("two fails addr", 64'(first_addr), 64'd3);
    check("two fails diff", 64'(first_diff), 64'h1);
    check("two fails cnt", 64'(fail_cnt), 64'd2);
    cyc(s_start);
    cyc(rd(3, 32'h1, 32'h0, 0, 32'h1, 0));
    cyc(rd(7, 32'h80, 32'h0, 0, 32'h1, 0));
    cyc(idle()); cyc(idle());
    check("masked addr", 64'(first_addr), 64'd7);
    check("masked diff", 64'(first_diff), 64'h80);
    check("masked cnt", 64'(fail_cnt), 64'd1);

    // stop_on_fail: addr 2 freezes, addr 3 (in flight) retires, addr 5 ignored
    cyc(s_start);
    for (int a = 0; a < 7; a++)
      cyc(rd(a, (a == 2 || a == 3 || a == 5) ? 32'hF : 32'h0, 32'h0, 0, 32'h0, 1));
    cyc(idle()); cyc(idle());
    check("freeze frozen", 64'(frozen), 64'd1);
    check("freeze cnt", 64'(fail_cnt), 64'd2);
    check("freeze addr", 64'(first_addr), 64'd2);
    cyc(s_end);
    check("freeze end busy", 64'(busy), 64'd0);

    // saturation
    cyc(s_start);
    for (int i = 0; i < 300; i++) cyc(rd(i, 32'h1, 32'h0, 0, 32'h0, 0));
    cyc(idle()); cyc(idle());
    check("sat cnt", 64'(fail_cnt), 64'd255);
    for (int i = 0; i < 5; i++) cyc(rd(i, 32'h2, 32'h0, 0, 32'h0, 0));
    cyc(idle()); cyc(idle());
    check("sat hold", 64'(fail_cnt), 64'd255);

    // session_end with a fail in flight: it still retires
    cyc(s_start);
    cyc(rd(9, 32'h4, 32'h0, 0, 32'h0, 0));
    cyc(s_end); cyc(idle());
    check("end inflight addr", 64'(first_addr), 64'd9);
    check("end inflight busy", 64'(busy), 64'd0);

    // reset with fails in flight
    cyc(s_start);
    cyc(rd(1, 32'h1, 32'h0, 0, 32'h0, 0));
    cyc(rd(2, 32'h1, 32'h0, 0, 32'h0, 0));
    cyc(s_rst); cyc(idle());
    check("rst inflight sticky", 64'(fail_sticky), 64'd0);
    check("rst inflight pulse", 64'(fail_pulse), 64'd0);

    // start+end together with a fail in flight
    cyc(s_start);
    cyc(rd(4, 32'h1, 32'h0, 0, 32'h0, 0));
    cyc(s_both); cyc(idle());
    check("start+end busy", 64'(busy), 64'd1);
    check("start+end cnt", 64'(fail_cnt), 64'd0);
    check("start+end pulse", 64'(fail_pulse), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
